osd_wr_arbiter: RTL

- Shares the single OSD write port (25-bit write vector into the video domain) between two requesters.
  - The NIOS PIO write path uses toggle handshaking.
  - The hardware status overlay (controller/PPU-state display) uses a valid/grant handshake.
- Buffers CPU writes in a small FIFO and arbitrates round-robin.
- Optionally restricts writes to vertical blanking.
- Holds each issued vector stable for a fixed number of cycles so the video-clock side can sample it safely. Sits in the SYS_CLK domain between system_n64adv2 and the OSD.

---
 rtl/osd_wr_arbiter_pkg.sv | 23 ++
 rtl/osd_wr_fifo.sv | 57 +++++
 rtl/osd_wr_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/osd_wr_arbiter_pkg.sv
// Shared constants for the OSD write-port arbiter: vector layout, FSM encodings and source ids.
package osd_wr_arbiter_pkg;

   localparam int OSD_WRVEC_W = 25;

   // {wrctrl[1:0], wrdata[22:0]}
   localparam int WRCTRL_HI = 24;
   localparam int WRCTRL_LO = 23;
   localparam int WRDATA_HI = 22;
   localparam int WRDATA_LO = 0;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_ISSUE = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b10;

   typedef logic [OSD_WRVEC_W-1:0] osd_wrvec_t;

   typedef enum logic {
      SRC_CPU = 1'b0,
      SRC_HW  = 1'b1
   } src_t;

endpackage

// File: rtl/osd_wr_fifo.sv
// Single-clock FIFO for buffered CPU OSD writes; head entry is visible on pop_data without a read cycle.
module osd_wr_fifo
   import osd_wr_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = OSD_WRVEC_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CNTW-1:0]  count_reg;

   // Storage carries no reset; only the pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr_reg];
   assign full     = (count_reg == CNTW'(DEPTH));
   assign empty    = (count_reg == '0);

endmodule

// File: rtl/osd_wr_arbiter.sv
// Shares the OSD write port between the toggle-handshaked CPU path and the valid/grant overlay path,
// holding each issued vector stable for HOLD_CYC cycles followed by a one-cycle strobe-low gap.
module osd_wr_arbiter
   import osd_wr_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYC    = 4,
   parameter bit VBLANK_ONLY = 1'b1
) (
   input  logic                   SYS_CLK,
   input  logic                   SYS_nRST,
   input  logic                   osd_vsync_i,
   input  logic                   cpu_wr_toggle_i,
   input  logic [OSD_WRVEC_W-1:0] cpu_wrvec_i,
   output logic                   cpu_wr_ack_o,
   input  logic                   hw_req_i,
   input  logic [OSD_WRVEC_W-1:0] hw_wrvec_i,
   output logic                   hw_gnt_o,
   output logic [OSD_WRVEC_W-1:0] osd_wrvec_o,
   output logic                   osd_wr_strobe_o,
   output logic                   fifo_full_o,
   output logic                   overflow_o
);

   localparam int HCW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYC - 1);

   logic             toggle_reg;
   logic             ack_reg;
   logic             ovf_reg;
   logic             gnt_reg, gnt_next;
   src_t             rr_reg, rr_next;
   logic [1:0]       state_reg, state_next;
   logic [HCW-1:0]   hold_reg, hold_next;
   osd_wrvec_t       vec_reg, vec_next;

   logic             wr_detect;
   logic             eligible;
   logic             cpu_pending;
   logic             pick_valid;
   src_t             pick_src;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   osd_wrvec_t       fifo_head;

   osd_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (OSD_WRVEC_W)
   ) u_cpu_fifo (
      .clk       (SYS_CLK),
      .rst_n     (SYS_nRST),
      .push      (fifo_push),
      .push_data (cpu_wrvec_i),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign wr_detect   = cpu_wr_toggle_i ^ toggle_reg;
   assign eligible    = !VBLANK_ONLY || !osd_vsync_i;
   assign cpu_pending = !fifo_empty;
   assign pick_valid  = (state_reg == ST_IDLE) && eligible && (cpu_pending || hw_req_i);

   // With both sources waiting the pointer decides; otherwise whoever is pending wins.
   always_comb begin
      pick_src = SRC_CPU;
      if (cpu_pending && hw_req_i) begin
         pick_src = rr_reg;
      end else if (!cpu_pending) begin
         pick_src = SRC_HW;
      end
   end

   assign fifo_pop  = pick_valid && (pick_src == SRC_CPU);
   assign fifo_push = wr_detect && (!fifo_full || fifo_pop);

   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      vec_next   = vec_reg;
      rr_next    = rr_reg;
      gnt_next   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               vec_next   = (pick_src == SRC_CPU) ? fifo_head : hw_wrvec_i;
               hold_next  = HOLD_INIT;
               rr_next    = (pick_src == SRC_CPU) ? SRC_HW : SRC_CPU;
               gnt_next   = (pick_src == SRC_HW);
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (hold_reg == '0) begin
               state_next = ST_GAP;
            end else begin
               hold_next = hold_reg - 1'b1;
            end
         end
         ST_GAP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge SYS_CLK or negedge SYS_nRST) begin
      if (!SYS_nRST) begin
         toggle_reg <= 1'b0;
         ack_reg    <= 1'b0;
         ovf_reg    <= 1'b0;
         gnt_reg    <= 1'b0;
         rr_reg     <= SRC_CPU;
         state_reg  <= ST_IDLE;
         hold_reg   <= '0;
         vec_reg    <= '0;
      end else begin
         toggle_reg <= cpu_wr_toggle_i;
         if (fifo_push) begin
            ack_reg <= cpu_wr_toggle_i;
         end
         // A rejected toggle is lost; the CPU must re-toggle after seeing no ack.
         if (wr_detect && !fifo_push) begin
            ovf_reg <= 1'b1;
         end
         gnt_reg   <= gnt_next;
         rr_reg    <= rr_next;
         state_reg <= state_next;
         hold_reg  <= hold_next;
         vec_reg   <= vec_next;
      end
   end

   // Strobe decodes straight from state so an asynchronous reset drops it immediately.
   assign osd_wr_strobe_o = (state_reg == ST_ISSUE);
   assign osd_wrvec_o     = vec_reg;
   assign cpu_wr_ack_o    = ack_reg;
   assign hw_gnt_o        = gnt_reg;
   assign fifo_full_o     = fifo_full;
   assign overflow_o      = ovf_reg;

endmodule
